// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial sequence detector with run-time overlap select,
// sample enable and a saturating, clearable match counter.
module seq_detector_param #(
    parameter int             N       = 6,
    parameter logic [N-1:0]   PATTERN = 6'b101111,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_count
);

    // state | meaning
    // k=0   | no prefix of PATTERN matched (empty history)
    // k=i   | the first i bits of PATTERN are the most recent i samples
    // k=N-1 | one bit short of a match; x==PATTERN[0] completes it

    localparam int KW = (N > 1) ? $clog2(N) : 1;

    generate
        if (N < 2 || N > 16 || CNT_W < 1) begin : g_bad_params
            $error("seq_detector_param: need 2 <= N <= 16 and CNT_W >= 1");
        end
    endgenerate

    // Failure table: entry (2*k + bit) is the longest prefix of PATTERN that
    // is a suffix of (first k pattern bits followed by bit), capped below N.
    function automatic logic [2*N*KW-1:0] build_kmp();
        logic [2*N*KW-1:0] tbl;
        int   best;
        int   j;
        logic ok;
        logic sb;
        tbl = '0;
        for (int k = 0; k < N; k++) begin
            for (int b = 0; b < 2; b++) begin
                best = 0;
                for (int l = 1; l <= k + 1; l++) begin
                    if (l < N) begin
                        ok = 1'b1;
                        for (int i = 0; i < l; i++) begin
                            j  = k + 1 - l + i;
                            sb = (j == k) ? (b == 1) : PATTERN[N-1-j];
                            if (PATTERN[N-1-i] != sb) ok = 1'b0;
                        end
                        if (ok) best = l;
                    end
                end
                tbl[(2*k+b)*KW +: KW] = KW'(best);
            end
        end
        return tbl;
    endfunction

    function automatic logic [KW-1:0] build_border();
        int   best;
        logic ok;
        best = 0;
        for (int l = 1; l < N; l++) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                if (PATTERN[N-1-i] != PATTERN[l-1-i]) ok = 1'b0;
            end
            if (ok) best = l;
        end
        return KW'(best);
    endfunction

    localparam logic [2*N*KW-1:0] KMP_TBL = build_kmp();
    localparam logic [KW-1:0]     B_LEN   = build_border();
    localparam logic [KW-1:0]     K_LAST  = KW'(N - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [KW-1:0] k;
    logic [KW-1:0] kmp_next;
    logic          match;

    assign match = en && (k == K_LAST) && (x == PATTERN[0]);
    assign z     = match && rst;

    always_comb begin
        kmp_next = '0;
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                if (x) kmp_next = KMP_TBL[(2*i+1)*KW +: KW];
                else   kmp_next = KMP_TBL[(2*i)*KW +: KW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            k           <= '0;
            match_count <= '0;
        end else begin
            if (en) begin
                if (match) k <= overlap ? B_LEN : '0;
                else       k <= kmp_next;
            end
            // A clear wins over a coincident match; that match goes uncounted.
            if (cnt_clr)
                match_count <= '0;
            else if (match && match_count != CNT_MAX)
                match_count <= match_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: stimulus pushes expected z/count,
// a negedge monitor pops and compares. Three configurations share the inputs.
module tb_seq_detector_param;

    logic clk;
    logic rst;
    logic en;
    logic x;
    logic ov;
    logic clr;

    logic       z0, z1, z2;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [7:0] cnt2;

    seq_detector_param #(.N(6), .PATTERN(6'b101111), .CNT_W(8)) u_dflt (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(ov), .cnt_clr(clr),
        .z(z0), .match_count(cnt0)
    );

    seq_detector_param #(.N(6), .PATTERN(6'b101111), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(ov), .cnt_clr(clr),
        .z(z1), .match_count(cnt1)
    );

    seq_detector_param #(.N(4), .PATTERN(4'b1010), .CNT_W(8)) u_n4 (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(ov), .cnt_clr(clr),
        .z(z2), .match_count(cnt2)
    );

    typedef struct {
        int   tag;
        int   sel;
        logic ez;
        int   ecnt;
        logic chk;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   tag   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        exp_t e;
        logic az;
        int   ac;
        if (q.size() > 0) begin
            e = q.pop_front();
            case (e.sel)
                0:       begin az = z0; ac = int'(cnt0); end
                1:       begin az = z1; ac = int'(cnt1); end
                default: begin az = z2; ac = int'(cnt2); end
            endcase
            total++;
            if (az !== e.ez) begin
                bad++;
                $display("FAIL z step=%0d dut=%0d got=%b want=%b", e.tag, e.sel, az, e.ez);
            end
            if (e.chk) begin
                total++;
                if (ac != e.ecnt) begin
                    bad++;
                    $display("FAIL match_count step=%0d dut=%0d got=%0d want=%0d",
                             e.tag, e.sel, ac, e.ecnt);
                end
            end
        end
    end

    task automatic send(input int sel, input logic e_en, input logic e_x, input logic e_ov,
                        input logic e_clr, input logic e_rst, input logic ez,
                        input int ecnt, input logic chk);
        exp_t item;
        @(posedge clk);
        #1;
        en  = e_en;
        x   = e_x;
        ov  = e_ov;
        clr = e_clr;
        rst = e_rst;
        tag++;
        item.tag  = tag;
        item.sel  = sel;
        item.ez   = ez;
        item.ecnt = ecnt;
        item.chk  = chk;
        q.push_back(item);
    endtask

    task automatic do_reset(input int sel);
        send(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic idle(input int sel, input int ecnt);
        send(sel, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ecnt, 1'b1);
    endtask

    // Bits and expected z are given MSB-first; cnt tracks the hand-listed matches.
    task automatic run_stream(input int sel, input logic [31:0] bits, input logic [31:0] expz,
                              input int len, input logic e_ov, inout int cnt, input int cmax);
        logic b;
        logic ez;
        for (int i = 0; i < len; i++) begin
            b  = bits[len-1-i];
            ez = expz[len-1-i];
            send(sel, 1'b1, b, e_ov, 1'b0, 1'b1, ez, cnt, 1'b1);
            if (ez && cnt < cmax) cnt++;
        end
    endtask

    initial begin : stim
        int cnt;
        rst = 1'b0;
        en  = 1'b0;
        x   = 1'b0;
        ov  = 1'b0;
        clr = 1'b0;

        // Default params, overlapping
        do_reset(0);
        cnt = 0;
        run_stream(0, 32'b11011110010111101111, 32'b00000010000000100001, 20, 1'b1, cnt, 255);
        idle(0, 3);

        // Same stream, non-overlapping
        do_reset(0);
        cnt = 0;
        run_stream(0, 32'b11011110010111101111, 32'b00000010000000100000, 20, 1'b0, cnt, 255);
        idle(0, 2);

        // Enable gating
        do_reset(0);
        cnt = 0;
        run_stream(0, 32'b101, 32'b000, 3, 1'b1, cnt, 255);
        send(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        send(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        send(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        run_stream(0, 32'b111, 32'b001, 3, 1'b1, cnt, 255);
        idle(0, 1);

        // Saturation at CNT_W=2, then clear coincident with a match
        do_reset(1);
        cnt = 0;
        run_stream(1, {6'b101111, 20'b01111011110111101111},
                      {6'b000001, 20'b00001000010000100001}, 26, 1'b1, cnt, 3);
        run_stream(1, 32'b0111, 32'b0000, 4, 1'b1, cnt, 3);
        send(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b1);
        idle(1, 0);

        // Reset in the cycle that would complete the pattern
        do_reset(0);
        cnt = 0;
        run_stream(0, 32'b10111, 32'b00000, 5, 1'b1, cnt, 255);
        send(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        cnt = 0;
        run_stream(0, 32'b101111, 32'b000001, 6, 1'b1, cnt, 255);
        idle(0, 1);

        // N=4, PATTERN=1010, overlapping then non-overlapping
        do_reset(2);
        cnt = 0;
        run_stream(2, 32'b101010, 32'b000101, 6, 1'b1, cnt, 255);
        idle(2, 2);
        do_reset(2);
        cnt = 0;
        run_stream(2, 32'b101010, 32'b000100, 6, 1'b0, cnt, 255);
        idle(2, 1);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
